qkv_stream_sched: RTL and testbench
===================================

// Module: qkv_stream_sched
// PURPOSE
//  Sequences one attention pass into dot_product: reads Q, K, V rows from on-chip SRAM and streams them over
//  the Q/K/V valid/ready channels. Each Q row is sent once; for every Q row, K/V rows 0..`MAX_SEQ_LENGTH-1 follow
//  in order, matching dot_product's fixed per-Q row count. Sits between the QKV SRAM buffers and dot_product.
// PARAMETERS
//  MAX_Q_ROWS  `MAX_SEQ_LENGTH  max Q rows per pass; sets Q address width QA_W=$clog2(MAX_Q_ROWS)
//  KV_ROWS     `MAX_SEQ_LENGTH  K/V rows per Q row; KA_W=$clog2(KV_ROWS); must equal dot_product row count
//  FIFO_DEPTH  2                per-stream output buffer depth; >=2 for full throughput at 1-cycle SRAM latency
// PORTS
//  clk          in   1         clock, all state on rising edge
//  rst_n        in   1         asynchronous active-low reset
//  start        in   1         begin pass; sampled only in IDLE
//  abort        in   1         synchronous flush to IDLE from any state; wins over start
//  num_q_cfg    in   QA_W+1    Q rows this pass (0..MAX_Q_ROWS); latched on accepted start
//  busy         out  1         high in RUN/DRAIN
//  done         out  1         one-cycle pulse on pass completion
//  q_rd_en      out  1         Q SRAM read strobe
//  q_rd_addr    out  QA_W      Q SRAM row address
//  q_rd_data    in   Q_VECTOR_T Q SRAM data, valid exactly 1 cycle after q_rd_en
//  kv_rd_en     out  1         shared K and V SRAM read strobe
//  kv_rd_addr   out  KA_W      shared K/V row address
//  k_rd_data    in   K_VECTOR_T K data, 1-cycle latency
//  v_rd_data    in   V_VECTOR_T V data, 1-cycle latency
//  Q_vld_out / Q_rdy_in / q_out   out/in/out  1/1/Q_VECTOR_T  Q channel to dot_product
//  K_vld_out / K_rdy_in / k_out   out/in/out  1/1/K_VECTOR_T  K channel
//  V_vld_out / V_rdy_in / v_out   out/in/out  1/1/V_VECTOR_T  V channel
// BEHAVIOUR
//  Reset: state=IDLE, all counters/FIFOs/in-flight flags cleared; busy=done=0, all rd_en=0, all *_vld_out=0,
//   addresses 0, data outputs '0.
//  FSM IDLE->RUN on start&&num_q_cfg!=0; IDLE->DONE on start&&num_q_cfg==0 (no reads). RUN->DRAIN when last
//   Q read and last K/V read issued. DRAIN->DONE when all FIFOs empty and no read in flight. DONE: done=1 for
//   one cycle, ->IDLE. abort: any state->IDLE next cycle, FIFOs and in-flight data discarded, no done pulse.
//  Credit rule: stream may issue a read only if fifo_count + inflight < FIFO_DEPTH (K/V: both FIFOs checked).
//   Read data written to FIFO the cycle after rd_en; never dropped, never backpressures SRAM.
//  Q stream: q_rd_addr = q_idx, 0..num_q-1, one read each; issues as soon as credit allows (may prefetch ahead).
//  K/V stream: kv_rd_addr = kv_idx, 0..KV_ROWS-1, wraps to 0 and increments kv_pass; total num_q*KV_ROWS reads.
//   K and V FIFOs written together, drained independently by K_rdy_in / V_rdy_in.
//  Channels: *_vld_out = FIFO non-empty; data = FIFO head; pop on vld&&rdy. vld stays high, data stable, until
//   accepted. Simultaneous push and pop on a full FIFO is legal only via credit (never overflows).
//  Latency: start to first Q_vld_out/K_vld_out = 2 cycles (RUN entry, SRAM read). Steady state 1 K/V per cycle
//   while dot_product ready.
//  start while busy ignored; num_q_cfg changes during pass ignored. rst_n deassertion mid-pass: pass lost.
//  Counter widths sized to count num_q inclusive; no overflow at num_q_cfg=MAX_Q_ROWS.
// STRUCTURE
//  sys_defs.svh: Q/K/V_VECTOR_T, `MAX_SEQ_LENGTH; add SCHED_STATE_T enum {IDLE,RUN,DRAIN,DONE}.
//  One sub-module: stream_fifo #(.T, .DEPTH) (count, push, pop, head, flush); instantiated three times.
//  Top holds FSM, Q/KV address counters, credit logic, in-flight flags.
// TESTING
//  KV_ROWS=4, num_q=2, ready always 1 -> Q addrs 0,1; KV addrs 0,1,2,3,0,1,2,3; done 1 pulse; 8 K beats.
//  Random K_rdy_in/V_rdy_in/Q_rdy_in stalls (50%) -> no beat lost/duplicated, data stable while vld&&!rdy,
//   FIFO count never >2, stream order matches address order.
//  start with num_q_cfg=0 -> no rd_en ever, done pulse 2 cycles after start, busy never high.
//  abort during RUN after 5 K/V reads -> next cycle IDLE, all vld 0, no done; new start restarts at addr 0.
//  rst_n asserted mid-pass (async, between edges) -> outputs to reset values immediately; start works after.
//  start pulsed while busy, num_q_cfg changed mid-pass -> ignored; pass completes with latched count.

Source files
------------

// File: rtl/qkv_stream_sched_pkg.sv
// Shared types for the Q/K/V stream scheduler: vector formats, sequence length and FSM states.
package qkv_stream_sched_pkg;

  localparam int MAX_SEQ_LENGTH = 4;
  localparam int ELEM_W         = 8;
  localparam int VEC_DIM        = 4;

  localparam int Q_VEC_W = ELEM_W * VEC_DIM;
  localparam int K_VEC_W = ELEM_W * VEC_DIM;
  localparam int V_VEC_W = ELEM_W * VEC_DIM;

  typedef logic [Q_VEC_W-1:0] Q_VECTOR_T;
  typedef logic [K_VEC_W-1:0] K_VECTOR_T;
  typedef logic [V_VEC_W-1:0] V_VECTOR_T;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } SCHED_STATE_T;

  // A read may issue only if the row it returns is guaranteed a FIFO slot; a pop
  // in the same cycle frees one, which is what sustains one row per cycle.
  function automatic logic credit_ok(input int cnt, input int infl, input int pop, input int depth);
    return (cnt + infl) < (depth + pop);
  endfunction

endpackage

// File: rtl/qkv_stream_sched_fifo.sv
// Small synchronous FIFO buffering one read stream toward dot_product.
// Occupancy is bounded by the caller's credit check, so push is never refused.
module qkv_stream_sched_fifo
  import qkv_stream_sched_pkg::*;
#(
  parameter type T         = logic,
  parameter int  DEPTH     = 2,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  T                 din,
  input  logic             pop,
  output T                 head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/qkv_stream_sched.sv
// Attention-pass sequencer: fetches Q rows once and K/V rows 0..KV_ROWS-1 per Q row
// from SRAM and streams them to dot_product over independent valid/ready channels.
module qkv_stream_sched
  import qkv_stream_sched_pkg::*;
#(
  parameter int  MAX_Q_ROWS = MAX_SEQ_LENGTH,
  parameter int  KV_ROWS    = MAX_SEQ_LENGTH,
  parameter int  FIFO_DEPTH = 2,
  localparam int QA_W       = $clog2(MAX_Q_ROWS),
  localparam int KA_W       = $clog2(KV_ROWS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [QA_W:0]      num_q_cfg,
  output logic               busy,
  output logic               done,
  output logic               q_rd_en,
  output logic [QA_W-1:0]    q_rd_addr,
  input  logic [Q_VEC_W-1:0] q_rd_data,
  output logic               kv_rd_en,
  output logic [KA_W-1:0]    kv_rd_addr,
  input  logic [K_VEC_W-1:0] k_rd_data,
  input  logic [V_VEC_W-1:0] v_rd_data,
  output logic               Q_vld_out,
  input  logic               Q_rdy_in,
  output logic [Q_VEC_W-1:0] q_out,
  output logic               K_vld_out,
  input  logic               K_rdy_in,
  output logic [K_VEC_W-1:0] k_out,
  output logic               V_vld_out,
  input  logic               V_rdy_in,
  output logic [V_VEC_W-1:0] v_out
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  SCHED_STATE_T     state_q, state_d;
  logic [QA_W:0]    num_q_q, num_q_d;
  logic [QA_W:0]    q_idx_q, q_idx_d;
  logic [QA_W:0]    kv_pass_q, kv_pass_d;
  logic [KA_W-1:0]  kv_idx_q, kv_idx_d;
  logic             q_infl_q, q_infl_d;
  logic             kv_infl_q, kv_infl_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] q_cnt, k_cnt, v_cnt;
  logic             q_empty, k_empty, v_empty;
  logic             q_pop, k_pop, v_pop;
  logic             accept_run, active, q_issue, kv_issue;
  logic [QA_W:0]    eff_num_q;

  // The first reads go out in the same cycle start is accepted, so the row is
  // already in its FIFO two edges later.
  always_comb begin
    accept_run = (state_q == IDLE) && start && !abort && (num_q_cfg != '0);
    active     = !abort && ((state_q == RUN) || accept_run);
    eff_num_q  = (state_q == IDLE) ? num_q_cfg : num_q_q;

    q_pop = !q_empty && Q_rdy_in;
    k_pop = !k_empty && K_rdy_in;
    v_pop = !v_empty && V_rdy_in;

    q_issue  = active && (q_idx_q < eff_num_q) &&
               credit_ok(int'(q_cnt), int'(q_infl_q), int'(q_pop), FIFO_DEPTH);
    kv_issue = active && (kv_pass_q < eff_num_q) &&
               credit_ok(int'(k_cnt), int'(kv_infl_q), int'(k_pop), FIFO_DEPTH) &&
               credit_ok(int'(v_cnt), int'(kv_infl_q), int'(v_pop), FIFO_DEPTH);
  end

  always_comb begin
    num_q_d   = accept_run ? num_q_cfg : num_q_q;
    q_idx_d   = q_idx_q;
    kv_idx_d  = kv_idx_q;
    kv_pass_d = kv_pass_q;
    if (abort || (state_q == DONE)) begin
      q_idx_d   = '0;
      kv_idx_d  = '0;
      kv_pass_d = '0;
    end else begin
      if (q_issue) begin
        q_idx_d = q_idx_q + (QA_W + 1)'(1);
      end
      if (kv_issue) begin
        if (kv_idx_q == KA_W'(KV_ROWS - 1)) begin
          kv_idx_d  = '0;
          kv_pass_d = kv_pass_q + (QA_W + 1)'(1);
        end else begin
          kv_idx_d  = kv_idx_q + KA_W'(1);
        end
      end
    end
    // SRAM data always returns one cycle after the strobe, so in-flight is just the delayed strobe.
    q_infl_d  = q_issue;
    kv_infl_d = kv_issue;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_q_cfg == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if ((q_idx_q == num_q_q) && (kv_pass_q == num_q_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (q_empty && k_empty && v_empty && !q_infl_q && !kv_infl_q) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
    end
    done_d = (state_q == DONE) && !abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      num_q_q   <= '0;
      q_idx_q   <= '0;
      kv_idx_q  <= '0;
      kv_pass_q <= '0;
      q_infl_q  <= 1'b0;
      kv_infl_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q_q   <= num_q_d;
      q_idx_q   <= q_idx_d;
      kv_idx_q  <= kv_idx_d;
      kv_pass_q <= kv_pass_d;
      q_infl_q  <= q_infl_d;
      kv_infl_q <= kv_infl_d;
      done_q    <= done_d;
    end
  end

  qkv_stream_sched_fifo #(.T(Q_VECTOR_T), .DEPTH(FIFO_DEPTH)) u_q_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (q_infl_q),
    .din   (q_rd_data),
    .pop   (q_pop),
    .head  (q_out),
    .count (q_cnt),
    .empty (q_empty)
  );

  qkv_stream_sched_fifo #(.T(K_VECTOR_T), .DEPTH(FIFO_DEPTH)) u_k_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (kv_infl_q),
    .din   (k_rd_data),
    .pop   (k_pop),
    .head  (k_out),
    .count (k_cnt),
    .empty (k_empty)
  );

  qkv_stream_sched_fifo #(.T(V_VECTOR_T), .DEPTH(FIFO_DEPTH)) u_v_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (kv_infl_q),
    .din   (v_rd_data),
    .pop   (v_pop),
    .head  (v_out),
    .count (v_cnt),
    .empty (v_empty)
  );

  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = done_q;
  assign q_rd_en    = q_issue;
  assign q_rd_addr  = q_idx_q[QA_W-1:0];
  assign kv_rd_en   = kv_issue;
  assign kv_rd_addr = kv_idx_q;
  assign Q_vld_out  = !q_empty;
  assign K_vld_out  = !k_empty;
  assign V_vld_out  = !v_empty;

endmodule

// File: tb/tb_qkv_stream_sched.sv
// Directed bench for qkv_stream_sched with an SRAM model and queue scoreboard.
module tb_qkv_stream_sched;
  import qkv_stream_sched_pkg::*;

  localparam int QA_W = $clog2(MAX_SEQ_LENGTH);
  localparam int KA_W = $clog2(MAX_SEQ_LENGTH);
  localparam int KV_ROWS = MAX_SEQ_LENGTH;

  logic               clk = 1'b0;
  logic               rst_n, start, abort;
  logic [QA_W:0]      num_q_cfg;
  logic               busy, done, q_rd_en, kv_rd_en;
  logic [QA_W-1:0]    q_rd_addr;
  logic [KA_W-1:0]    kv_rd_addr;
  logic [Q_VEC_W-1:0] q_rd_data, q_out;
  logic [K_VEC_W-1:0] k_rd_data, k_out;
  logic [V_VEC_W-1:0] v_rd_data, v_out;
  logic               Q_vld_out, Q_rdy_in, K_vld_out, K_rdy_in, V_vld_out, V_rdy_in;

  int checks = 0;
  int errors = 0;
  logic [7:0] salt = 8'h00;
  bit mon_en = 1'b0;
  int done_cnt = 0;
  int kv_rd_count = 0;
  int k_beats = 0;

  int          exp_qa[$];
  int          exp_kva[$];
  logic [31:0] exp_qd[$];
  logic [31:0] exp_kd[$];
  logic [31:0] exp_vd[$];

  logic        prev_qv, prev_qr, prev_kv, prev_kr, prev_vv, prev_vr, prev_done;
  logic [31:0] prev_qd, prev_kd, prev_vd;

  always #5 clk = ~clk;

  qkv_stream_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_q_cfg(num_q_cfg),
    .busy(busy), .done(done),
    .q_rd_en(q_rd_en), .q_rd_addr(q_rd_addr), .q_rd_data(q_rd_data),
    .kv_rd_en(kv_rd_en), .kv_rd_addr(kv_rd_addr), .k_rd_data(k_rd_data), .v_rd_data(v_rd_data),
    .Q_vld_out(Q_vld_out), .Q_rdy_in(Q_rdy_in), .q_out(q_out),
    .K_vld_out(K_vld_out), .K_rdy_in(K_rdy_in), .k_out(k_out),
    .V_vld_out(V_vld_out), .V_rdy_in(V_rdy_in), .v_out(v_out)
  );

  function automatic logic [31:0] qdat(input int a);
    return {8'h51, salt, 8'h00, 8'(a)};
  endfunction
  function automatic logic [31:0] kdat(input int a);
    return {8'h4B, salt, 8'h00, 8'(a)};
  endfunction
  function automatic logic [31:0] vdat(input int a);
    return {8'h56, salt, 8'h00, 8'(a)};
  endfunction

  // SRAM model: one-cycle read latency, junk on the bus when not reading.
  always @(posedge clk) begin
    q_rd_data <= q_rd_en  ? qdat(int'(q_rd_addr))  : 32'hDEAD_0001;
    k_rd_data <= kv_rd_en ? kdat(int'(kv_rd_addr)) : 32'hDEAD_0002;
    v_rd_data <= kv_rd_en ? vdat(int'(kv_rd_addr)) : 32'hDEAD_0003;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pass(input int n);
    for (int i = 0; i < n; i++) begin
      exp_qa.push_back(i);
      exp_qd.push_back(qdat(i));
    end
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < KV_ROWS; i++) begin
        exp_kva.push_back(i);
        exp_kd.push_back(kdat(i));
        exp_vd.push_back(vdat(i));
      end
    end
  endtask

  task automatic clear_expect();
    exp_qa.delete(); exp_kva.delete(); exp_qd.delete(); exp_kd.delete(); exp_vd.delete();
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_q_addr_left"}, exp_qa.size(), 0);
    chk({tag, "_kv_addr_left"}, exp_kva.size(), 0);
    chk({tag, "_q_beats_left"}, exp_qd.size(), 0);
    chk({tag, "_k_beats_left"}, exp_kd.size(), 0);
    chk({tag, "_v_beats_left"}, exp_vd.size(), 0);
  endtask

  task automatic pulse_start(input logic [QA_W:0] n);
    @(posedge clk); #1;
    num_q_cfg = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int  base = done_cnt;
    bit  seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(posedge clk); #1;
      if (rnd) begin
        Q_rdy_in = 1'($urandom_range(0, 1));
        K_rdy_in = 1'($urandom_range(0, 1));
        V_rdy_in = 1'($urandom_range(0, 1));
      end
      if (done_cnt != base) seen = 1'b1;
    end
    Q_rdy_in = 1'b1; K_rdy_in = 1'b1; V_rdy_in = 1'b1;
    chk("pass_done_within_budget", seen, 1);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q_rd_en) begin
        chk("q_rd_expected", exp_qa.size() != 0, 1);
        if (exp_qa.size() != 0) chk("q_rd_addr", q_rd_addr, exp_qa.pop_front());
      end
      if (kv_rd_en) begin
        kv_rd_count++;
        chk("kv_rd_expected", exp_kva.size() != 0, 1);
        if (exp_kva.size() != 0) chk("kv_rd_addr", kv_rd_addr, exp_kva.pop_front());
      end
      if (Q_vld_out && Q_rdy_in) begin
        chk("q_beat_expected", exp_qd.size() != 0, 1);
        if (exp_qd.size() != 0) chk("q_beat_data", q_out, exp_qd.pop_front());
      end
      if (K_vld_out && K_rdy_in) begin
        k_beats++;
        chk("k_beat_expected", exp_kd.size() != 0, 1);
        if (exp_kd.size() != 0) chk("k_beat_data", k_out, exp_kd.pop_front());
      end
      if (V_vld_out && V_rdy_in) begin
        chk("v_beat_expected", exp_vd.size() != 0, 1);
        if (exp_vd.size() != 0) chk("v_beat_data", v_out, exp_vd.pop_front());
      end
      if (prev_qv && !prev_qr) begin
        chk("q_hold_vld", Q_vld_out, 1);
        chk("q_hold_data", q_out, prev_qd);
      end
      if (prev_kv && !prev_kr) begin
        chk("k_hold_vld", K_vld_out, 1);
        chk("k_hold_data", k_out, prev_kd);
      end
      if (prev_vv && !prev_vr) begin
        chk("v_hold_vld", V_vld_out, 1);
        chk("v_hold_data", v_out, prev_vd);
      end
      if (done) begin
        done_cnt++;
        chk("done_single_cycle", prev_done, 0);
      end
    end
    prev_qv = mon_en && Q_vld_out; prev_qr = Q_rdy_in; prev_qd = q_out;
    prev_kv = mon_en && K_vld_out; prev_kr = K_rdy_in; prev_kd = k_out;
    prev_vv = mon_en && V_vld_out; prev_vr = V_rdy_in; prev_vd = v_out;
    prev_done = done;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_q_cfg = '0;
    Q_rdy_in = 1'b1; K_rdy_in = 1'b1; V_rdy_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q_rd_en", q_rd_en, 0);
    chk("rst_kv_rd_en", kv_rd_en, 0);
    chk("rst_vld", {Q_vld_out, K_vld_out, V_vld_out}, 0);
    chk("rst_addrs", {q_rd_addr, kv_rd_addr}, 0);
    chk("rst_data", {q_out, k_out}, 0);
    chk("rst_v_data", v_out, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Basic pass: two Q rows, ready always high.
    salt = 8'h01; expect_pass(2); base = done_cnt; kv_rd_count = 0; k_beats = 0;
    @(posedge clk); #1;
    num_q_cfg = 2; start = 1'b1;
    @(negedge clk);
    chk("t1_c0_q_rd_en", q_rd_en, 1);
    chk("t1_c0_kv_rd_en", kv_rd_en, 1);
    chk("t1_c0_busy", busy, 0);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("t1_c1_busy", busy, 1);
    chk("t1_c1_q_vld", Q_vld_out, 0);
    @(negedge clk);
    chk("t1_c2_q_vld", Q_vld_out, 1);
    chk("t1_c2_k_vld", K_vld_out, 1);
    wait_done(200, 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("t1_done_pulses", done_cnt - base, 1);
    chk("t1_kv_reads", kv_rd_count, 8);
    chk("t1_k_beats", k_beats, 8);
    chk("t1_busy_after", busy, 0);
    check_drained("t1");

    // Maximum Q count with random backpressure on all three channels.
    salt = 8'h02; expect_pass(MAX_SEQ_LENGTH); base = done_cnt; k_beats = 0;
    pulse_start((QA_W + 1)'(MAX_SEQ_LENGTH));
    wait_done(1000, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("t2_done_pulses", done_cnt - base, 1);
    chk("t2_k_beats", k_beats, MAX_SEQ_LENGTH * KV_ROWS);
    check_drained("t2");

    // Zero-length pass: no reads, done two cycles after start, never busy.
    salt = 8'h03; base = done_cnt;
    @(posedge clk); #1;
    num_q_cfg = 0; start = 1'b1;
    @(negedge clk);
    chk("t3_c0_rd_en", {q_rd_en, kv_rd_en}, 0);
    chk("t3_c0_busy", busy, 0);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("t3_c1_done", done, 0);
    chk("t3_c1_busy", busy, 0);
    @(negedge clk);
    chk("t3_c2_done", done, 1);
    chk("t3_c2_busy", busy, 0);
    @(negedge clk);
    chk("t3_c3_done", done, 0);
    chk("t3_done_pulses", done_cnt - base, 1);

    // Abort after five K/V reads, then a fresh pass restarts at address 0.
    salt = 8'h04; expect_pass(3); base = done_cnt; kv_rd_count = 0;
    @(posedge clk); #1;
    num_q_cfg = 3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 50 && kv_rd_count < 5; c++) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    clear_expect();
    chk("t4_kv_reads_at_abort", kv_rd_count, 5);
    chk("t4_busy_after_abort", busy, 0);
    chk("t4_vld_after_abort", {Q_vld_out, K_vld_out, V_vld_out}, 0);
    repeat (4) @(posedge clk); #1;
    chk("t4_no_done", done_cnt - base, 0);
    chk("t4_no_more_reads", kv_rd_count, 5);
    salt = 8'h05; expect_pass(1); base = done_cnt;
    @(posedge clk); #1;
    num_q_cfg = 1; start = 1'b1;
    @(negedge clk);
    chk("t4_restart_kv_rd_en", kv_rd_en, 1);
    chk("t4_restart_addrs", {q_rd_addr, kv_rd_addr}, 0);
    @(posedge clk); #1; start = 1'b0;
    wait_done(200, 1'b0);
    repeat (2) @(posedge clk); #1;
    chk("t4_restart_done", done_cnt - base, 1);
    check_drained("t4");

    // Asynchronous reset between edges in the middle of a pass.
    salt = 8'h06; expect_pass(3);
    pulse_start(3);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_vld", {Q_vld_out, K_vld_out, V_vld_out}, 0);
    chk("t5_rst_rd_en", {q_rd_en, kv_rd_en}, 0);
    chk("t5_rst_addrs", {q_rd_addr, kv_rd_addr}, 0);
    chk("t5_rst_data", {q_out, k_out}, 0);
    chk("t5_rst_done", done, 0);
    clear_expect();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    mon_en = 1'b1;
    salt = 8'h07; expect_pass(2); base = done_cnt;
    pulse_start(2);
    wait_done(200, 1'b0);
    repeat (2) @(posedge clk); #1;
    chk("t5_after_rst_done", done_cnt - base, 1);
    check_drained("t5");

    // start re-pulsed and num_q_cfg changed while busy: both ignored.
    salt = 8'h08; expect_pass(2); base = done_cnt;
    pulse_start(2);
    repeat (3) @(posedge clk); #1;
    num_q_cfg = 3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(200, 1'b0);
    repeat (5) @(posedge clk); #1;
    chk("t6_done_pulses", done_cnt - base, 1);
    chk("t6_idle_after", busy, 0);
    check_drained("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
